data_mem_sized: RTL and testbench

//  Byte-addressed, parametrised data memory for the pipelined RV32I core's MEM stage.

---
 rtl/data_mem_sized.sv | 70 +++++++
 tb/tb_data_mem_sized.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/data_mem_sized.sv
// data_mem_sized: byte-addressed RV32I data memory with sized loads/stores and error reporting
module data_mem_sized #(
  parameter int ADDR_W = 14,
  parameter INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err
);
  localparam int DEPTH = 2 ** (ADDR_W - 2);
  logic [31:0] mem [DEPTH];
  logic [ADDR_W-3:0] idx;
  logic [1:0] lane, err;
  logic ill, mis, oor, wr;
  logic [3:0] be;
  logic [31:0] wdata_rep, rd_word, sh, ld;
  logic rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0] rsp_err_q, rsp_err_d;
  always_comb begin
    idx = req_addr[ADDR_W-1:2];
    lane = req_addr[1:0];
    oor = |req_addr[31:ADDR_W];
    ill = req_we ? (req_funct3 > 3'd2) : (req_funct3 == 3'd3 || req_funct3 >= 3'd6);
    mis = (req_funct3[1:0] == 2'b01 && lane[0]) || (req_funct3[1:0] == 2'b10 && lane != 2'b00);
    err = ill ? 2'b11 : mis ? 2'b01 : oor ? 2'b10 : 2'b00;
    wr = req_valid && req_we && err == 2'b00;
    be = req_funct3[1:0] == 2'b00 ? 4'b0001 << lane :
         req_funct3[1:0] == 2'b01 ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_rep = req_funct3[1:0] == 2'b00 ? {4{req_wdata[7:0]}} :
                req_funct3[1:0] == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
    rd_word = mem[idx];
    sh = rd_word >> {lane, 3'b000};
    ld = req_funct3 == 3'b000 ? {{24{sh[7]}}, sh[7:0]} :
         req_funct3 == 3'b100 ? {24'b0, sh[7:0]} :
         req_funct3 == 3'b001 ? {{16{sh[15]}}, sh[15:0]} :
         req_funct3 == 3'b101 ? {16'b0, sh[15:0]} : rd_word;
    rsp_valid_d = req_valid;
    rsp_rdata_d = !req_valid ? rsp_rdata_q : (req_we || err != 2'b00) ? 32'b0 : ld;
    rsp_err_d = req_valid ? err : rsp_err_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
    end else if (wr) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'b0;
      rsp_err_q <= 2'b00;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q <= rsp_err_d;
    end
  end
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err = rsp_err_q;
endmodule

// File: tb/tb_data_mem_sized.sv
// tb_data_mem_sized: directed plus random requests checked against a byte-array model
// of RV32I sized memory semantics.
module tb_data_mem_sized;
  logic        clk = 0;
  logic        rst = 1;
  logic        req_valid = 0;
  logic        req_we = 0;
  logic [2:0]  req_funct3 = 0;
  logic [31:0] req_addr = 0;
  logic [31:0] req_wdata = 0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] mm [16384];
  logic [31:0] last_r = 0;
  logic [1:0] last_e = 0;

  data_mem_sized dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic v, input logic [31:0] d, input logic [1:0] e);
    vectors++;
    assert (rsp_valid === v) else begin
      miscompares++;
      $error("FAIL %s rsp_valid got %b want %b", tag, rsp_valid, v);
    end
    vectors++;
    assert (rsp_rdata === d) else begin
      miscompares++;
      $error("FAIL %s rsp_rdata got %h want %h", tag, rsp_rdata, d);
    end
    vectors++;
    assert (rsp_err === e) else begin
      miscompares++;
      $error("FAIL %s rsp_err got %b want %b", tag, rsp_err, e);
    end
  endtask

  // Reference: error by rule, then access as n consecutive little-endian bytes.
  task automatic step(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd);
    logic [1:0] e;
    logic [31:0] r;
    int n;
    n = 1 << f3[1:0];
    if (we ? (f3 > 2) : (f3 == 3 || f3 >= 6)) e = 2'b11;
    else if (a % n != 0) e = 2'b01;
    else if (a >= 32'h4000) e = 2'b10;
    else e = 2'b00;
    r = 0;
    if (e == 2'b00) begin
      if (we) for (int i = 0; i < n; i++) mm[int'(a) + i] = wd[8*i +: 8];
      else begin
        for (int i = 0; i < n; i++) r[8*i +: 8] = mm[int'(a) + i];
        if (!f3[2] && n == 1) r = 32'($signed(r[7:0]));
        if (!f3[2] && n == 2) r = 32'($signed(r[15:0]));
      end
    end
    req_valid = 1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    check(tag, 1'b1, r, e);
    last_r = r;
    last_e = e;
  endtask

  task automatic idle();
    req_valid = 0;
    req_we = $urandom_range(0, 1);
    req_addr = $urandom_range(0, 255);
    @(posedge clk);
    @(negedge clk);
    check("idle", 1'b0, last_r, last_e);
  endtask

  initial begin
    logic [31:0] a;
    int r;
    #12;
    check("reset", 1'b0, 32'h0, 2'b00);
    @(negedge clk);
    rst = 0;
    for (int w = 0; w < 64; w++) step("prefill", 1, 3'b010, 32'(w * 4), $urandom);
    step("sw1", 1, 3'b010, 32'h10, 32'hDEADBEEF);
    step("lw1", 0, 3'b010, 32'h10, 0);
    step("sb2", 1, 3'b000, 32'h11, 32'h7F);
    step("lw2", 0, 3'b010, 32'h10, 0);
    step("lb2", 0, 3'b000, 32'h13, 0);
    step("lbu2", 0, 3'b100, 32'h13, 0);
    step("sh3", 1, 3'b001, 32'h12, 32'h8001);
    step("lh3", 0, 3'b001, 32'h12, 0);
    step("lhu3", 0, 3'b101, 32'h12, 0);
    step("lw3", 0, 3'b010, 32'h10, 0);
    step("lwmis", 0, 3'b010, 32'h12, 0);
    step("shmis", 1, 3'b001, 32'h13, 32'hFFFF);
    step("lw4", 0, 3'b010, 32'h10, 0);
    step("lwoor", 0, 3'b010, 32'h4000, 0);
    step("swoor", 1, 3'b010, 32'h4010, 32'h12345678);
    step("ill011", 0, 3'b011, 32'h10, 0);
    step("illst", 1, 3'b100, 32'h10, 32'hFF);
    step("lw4b", 0, 3'b010, 32'h10, 0);
    idle();
    step("sw5", 1, 3'b010, 32'h20, 32'h1);
    step("lw5a", 0, 3'b010, 32'h20, 0);
    step("lw5b", 0, 3'b010, 32'h20, 0);
    idle();
    idle();
    // Async reset mid-cycle clears the pending response at once.
    req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h20;
    @(posedge clk);
    #2;
    check("rst_pre", 1'b1, 32'h1, 2'b00);
    rst = 1;
    #1;
    check("rst_async", 1'b0, 32'h0, 2'b00);
    @(negedge clk);
    req_we = 1; req_funct3 = 3'b010; req_addr = 32'h30; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    check("rst_st", 1'b0, 32'h0, 2'b00);
    rst = 0;
    last_r = 0;
    last_e = 0;
    idle();
    step("rst_lw", 0, 3'b010, 32'h30, 0);
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 15);
      a = $urandom_range(0, 255);
      if (r == 0) a = 32'h4000 + $urandom_range(0, 255);
      if (r == 1) a = $urandom | 32'h8000_0000;
      if (r == 2) idle();
      else step("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
